// File: rtl/cmd_proto_pkg.sv
// Shared definitions for the UART register-access protocol (master and parser).
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package cmd_proto_pkg;

    // Command opcodes on the wire ('W' and 'R')
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;

    // Master-side transaction state
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_CMD  = 3'd1,
        SEND_ADDR = 3'd2,
        SEND_DATA = 3'd3,
        WAIT_RSP  = 3'd4
    } state_t;

endpackage

// File: rtl/timeout_counter.sv
// Cycle counter that flags when it is about to reach TIMEOUT_CYCLES-1 (needs TIMEOUT_CYCLES >= 2).
// Latency: expire is combinational from the count; the count reaches TIMEOUT_CYCLES-1 on the edge ending an expire cycle.
// Backpressure: none; clear wins over enable, count saturates at TIMEOUT_CYCLES-1.
module timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LAST_CNT = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] PRE_LAST = TW'(TIMEOUT_CYCLES - 2);

    logic [TW-1:0] count;

    // Count enabled cycles since the last clear, saturating at the terminal value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST_CNT)) begin
            count <= count + TW'(1);
        end
    end

    // Raised in the cycle whose closing edge brings the count to TIMEOUT_CYCLES-1
    assign expire = enable && !clear && (count == PRE_LAST);

endmodule

// File: rtl/command_master_uart.sv
// UART register-access initiator: serializes read/write requests to bytes, assembles read responses.
// Latency: CMD byte one cycle after acceptance; response one cycle after the last rx byte.
// Backpressure: o_tx_valid holds stable data until i_tx_ready; requests accepted only in IDLE.
module command_master_uart
    import cmd_proto_pkg::*;
#(
    parameter int WORD_WIDTH     = 8,
    parameter int VALUE_WORDS    = 4,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1000000,
    localparam int DW            = WORD_WIDTH * VALUE_WORDS
) (
    input  logic                  clk,
    input  logic                  i_reset_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_write,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DW-1:0]         i_req_data,
    output logic [WORD_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    input  logic [WORD_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rsp_valid,
    output logic [DW-1:0]         o_rsp_data,
    output logic                  o_rsp_timeout,
    output logic                  o_busy
);

    localparam int CW = $clog2(VALUE_WORDS + 1);
    localparam logic [CW-1:0] LAST_BYTE = CW'(VALUE_WORDS - 1);
    localparam int SW = DW - WORD_WIDTH;

    state_t state;
    state_t state_nxt;

    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DW-1:0]         data_q;
    logic [CW-1:0]         tx_cnt;
    logic [CW-1:0]         rx_cnt;
    logic [SW-1:0]         rsp_shift;

    logic tx_hs;
    logic rx_last;
    logic to_clear;
    logic to_expire;
    logic in_wait;

    assign tx_hs    = o_tx_valid && i_tx_ready;
    assign in_wait  = (state == WAIT_RSP);
    assign rx_last  = in_wait && i_rx_valid && (rx_cnt == LAST_BYTE);
    // The timer restarts on the handshake that moves a read into WAIT_RSP
    assign to_clear = (state == SEND_ADDR) && tx_hs && !wr_q;

    assign o_req_ready = (state == IDLE);
    assign o_busy      = (state != IDLE);

    timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (i_reset_n),
        .clear  (to_clear),
        .enable (in_wait),
        .expire (to_expire)
    );

    // State register
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a final rx byte beats a simultaneous timeout (both return to IDLE)
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (i_req_valid) state_nxt = SEND_CMD;
            SEND_CMD:  if (tx_hs) state_nxt = SEND_ADDR;
            SEND_ADDR: if (tx_hs) state_nxt = wr_q ? SEND_DATA : WAIT_RSP;
            SEND_DATA: if (tx_hs && (tx_cnt == LAST_BYTE)) state_nxt = IDLE;
            WAIT_RSP:  if (rx_last || to_expire) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Request capture, tx byte serialization and response assembly
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_q          <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            tx_cnt        <= '0;
            rx_cnt        <= '0;
            rsp_shift     <= '0;
            o_tx_data     <= '0;
            o_tx_valid    <= 1'b0;
            o_rsp_valid   <= 1'b0;
            o_rsp_data    <= '0;
            o_rsp_timeout <= 1'b0;
        end else begin
            o_rsp_valid   <= 1'b0;
            o_rsp_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        wr_q       <= i_req_write;
                        addr_q     <= i_req_addr;
                        data_q     <= i_req_data;
                        tx_cnt     <= '0;
                        rx_cnt     <= '0;
                        o_tx_data  <= i_req_write ? WORD_WIDTH'(CMD_WRITE) : WORD_WIDTH'(CMD_READ);
                        o_tx_valid <= 1'b1;
                    end
                end
                SEND_CMD: begin
                    if (tx_hs) begin
                        o_tx_data <= WORD_WIDTH'(addr_q);
                    end
                end
                SEND_ADDR: begin
                    if (tx_hs) begin
                        if (wr_q) begin
                            o_tx_data <= data_q[DW-1 -: WORD_WIDTH];
                            data_q    <= {data_q[SW-1:0], {WORD_WIDTH{1'b0}}};
                        end else begin
                            o_tx_valid <= 1'b0;
                        end
                    end
                end
                SEND_DATA: begin
                    if (tx_hs) begin
                        if (tx_cnt == LAST_BYTE) begin
                            o_tx_valid <= 1'b0;
                        end else begin
                            o_tx_data <= data_q[DW-1 -: WORD_WIDTH];
                            data_q    <= {data_q[SW-1:0], {WORD_WIDTH{1'b0}}};
                            tx_cnt    <= tx_cnt + CW'(1);
                        end
                    end
                end
                WAIT_RSP: begin
                    if (i_rx_valid) begin
                        if (rx_cnt == LAST_BYTE) begin
                            o_rsp_data  <= {rsp_shift, i_rx_data};
                            o_rsp_valid <= 1'b1;
                        end else begin
                            rsp_shift <= {rsp_shift[SW-WORD_WIDTH-1:0], i_rx_data};
                            rx_cnt    <= rx_cnt + CW'(1);
                        end
                    end else if (to_expire) begin
                        o_rsp_timeout <= 1'b1;
                    end
                end
                default: begin
                    o_tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_command_master_uart.sv
// Scoreboarded bench for command_master_uart with a short timeout (16 cycles).
// Latency: n/a.
// Backpressure: i_tx_ready tied high except in the randomized stall test.
module tb_command_master_uart;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_write;
    logic [7:0]  i_req_addr;
    logic [31:0] i_req_data;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_data;
    logic        o_rsp_timeout;
    logic        o_busy;

    typedef struct {
        logic        is_timeout;
        logic [31:0] data;
    } rsp_t;

    logic [7:0]  exp_tx[$];
    rsp_t        exp_rsp[$];
    logic [31:0] reg_model [256];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    command_master_uart #(
        .WORD_WIDTH    (8),
        .VALUE_WORDS   (4),
        .ADDR_WIDTH    (8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk           (clk),
        .i_reset_n     (i_reset_n),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_write   (i_req_write),
        .i_req_addr    (i_req_addr),
        .i_req_data    (i_req_data),
        .o_tx_data     (o_tx_data),
        .o_tx_valid    (o_tx_valid),
        .i_tx_ready    (i_tx_ready),
        .i_rx_data     (i_rx_data),
        .i_rx_valid    (i_rx_valid),
        .o_rsp_valid   (o_rsp_valid),
        .o_rsp_data    (o_rsp_data),
        .o_rsp_timeout (o_rsp_timeout),
        .o_busy        (o_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string name, input logic [63:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0h expected nothing at %0t", name, act, $time);
    endtask

    // Monitor: pops expected tx bytes and responses, and checks tx hold while stalled
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    always @(negedge clk) begin
        if (!i_reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("tx_hold", {o_tx_valid, o_tx_data}, {1'b1, prev_data});
            if (o_tx_valid && i_tx_ready) begin
                if (exp_tx.size() == 0) flag_fail("tx_unexpected", o_tx_data);
                else chk("tx_byte", o_tx_data, exp_tx.pop_front());
            end
            if (o_rsp_valid || o_rsp_timeout) begin
                if (exp_rsp.size() == 0) begin
                    flag_fail("rsp_unexpected", {o_rsp_valid, o_rsp_timeout, o_rsp_data});
                end else begin
                    rsp_t e;
                    e = exp_rsp.pop_front();
                    chk("rsp_kind", {o_rsp_valid, o_rsp_timeout}, e.is_timeout ? 2'b01 : 2'b10);
                    chk("rsp_data", o_rsp_data, e.data);
                end
            end
            prev_stall = o_tx_valid && !i_tx_ready;
            prev_data  = o_tx_data;
        end
    end

    // Hand one request over the valid/ready port, then scramble the inputs
    task automatic send_req(input logic wr, input logic [7:0] addr, input logic [31:0] data);
        int n;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (o_req_ready) break;
            n++;
        end
        if (n == 100) flag_fail("req_ready_wait", 0);
        @(posedge clk); #1;
        i_req_valid = 1'b1; i_req_write = wr; i_req_addr = addr; i_req_data = data;
        @(posedge clk); #1;
        i_req_valid = 1'b0; i_req_write = ~wr; i_req_addr = ~addr; i_req_data = ~data;
    endtask

    task automatic wr_txn(input logic [7:0] addr, input logic [31:0] data, input bit timing);
        exp_tx.push_back(8'h57);
        exp_tx.push_back(addr);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(data[i*8 +: 8]);
        reg_model[addr] = data;
        send_req(1'b1, addr, data);
        if (timing) begin
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                chk("wr_tx_valid_b2b", o_tx_valid, 1'b1);
            end
            @(negedge clk);
            chk("wr_ready_after_last", {o_req_ready, o_tx_valid}, 2'b10);
        end
    endtask

    // Read with a scripted responder; gaps count idle cycles before each byte from WAIT_RSP entry
    task automatic rd_txn(input logic [7:0] addr, input logic [31:0] rdata, input int nbytes,
                          input int gaps[4], input bit exp_to, input logic [31:0] exp_data);
        rsp_t e;
        exp_tx.push_back(8'h52);
        exp_tx.push_back(addr);
        e.is_timeout = exp_to;
        e.data       = exp_data;
        exp_rsp.push_back(e);
        send_req(1'b0, addr, rdata);
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < nbytes; i++) begin
            repeat (gaps[i]) begin @(posedge clk); #1; end
            i_rx_valid = 1'b1;
            i_rx_data  = rdata[(3-i)*8 +: 8];
            @(posedge clk); #1;
            i_rx_valid = 1'b0;
        end
        if (nbytes == 4) begin
            @(negedge clk);
            chk("rd_rsp_next_cycle", {o_rsp_valid, o_rsp_timeout, o_req_ready}, 3'b101);
        end
    endtask

    initial begin
        int g[4];
        int n;
        i_reset_n   = 1'b0;
        i_req_valid = 1'b0;
        i_req_write = 1'b0;
        i_req_addr  = 8'h00;
        i_req_data  = 32'h0;
        i_tx_ready  = 1'b1;
        i_rx_data   = 8'h00;
        i_rx_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {o_req_ready, o_busy, o_tx_valid, o_rsp_valid, o_rsp_timeout}, 5'b10000);
        chk("reset_data", {o_tx_data, o_rsp_data}, 40'h0);
        i_reset_n = 1'b1;

        // Back-to-back write with ready tied high
        wr_txn(8'h02, 32'hDEADBEEF, 1'b1);

        // Read with 0..5 cycle gaps between response bytes
        g = '{0, 5, 3, 2};
        rd_txn(8'h01, 32'h12345678, 4, g, 1'b0, 32'h12345678);

        // Write under random tx_ready stalls
        send_req(1'b1, 8'h5A, 32'h0123A5C3);
        exp_tx.push_back(8'h57); exp_tx.push_back(8'h5A);
        exp_tx.push_back(8'h01); exp_tx.push_back(8'h23);
        exp_tx.push_back(8'hA5); exp_tx.push_back(8'hC3);
        n = 0;
        while (n < 200) begin
            @(posedge clk); #1;
            i_tx_ready = 1'($urandom_range(0, 1));
            if (o_req_ready && exp_tx.size() == 0) break;
            n++;
        end
        i_tx_ready = 1'b1;
        chk("stall_write_done", n < 200, 1'b1);
        chk("stall_no_lost_bytes", exp_tx.size(), 0);

        // Timeout after 2 of 4 bytes: pulse in cycle entry+15, data unchanged
        g = '{0, 0, 0, 0};
        rd_txn(8'h07, 32'hAABBCCDD, 2, g, 1'b1, 32'h12345678);
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("timeout_not_early", {o_rsp_timeout, o_busy}, 2'b01);
        @(negedge clk);
        chk("timeout_at_15", {o_rsp_timeout, o_req_ready}, 2'b11);

        // Last byte coincides with the would-be timeout cycle: byte wins
        g = '{0, 0, 0, 11};
        rd_txn(8'h07, 32'h89ABCDEF, 4, g, 1'b0, 32'h89ABCDEF);

        // Reset in the middle of a write, just after the addr byte
        exp_tx.push_back(8'h57); exp_tx.push_back(8'h33);
        send_req(1'b1, 8'h33, 32'h11223344);
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_reset_n = 1'b0;
        #1;
        chk("async_reset_ctrl", {o_req_ready, o_busy, o_tx_valid}, 3'b100);
        chk("async_reset_data", {o_tx_data, o_rsp_data}, 40'h0);
        repeat (2) @(posedge clk);
        #1;
        i_reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            i_rx_valid = 1'b1;
            i_rx_data  = 8'hF0 + 8'(i);
            @(posedge clk); #1;
            i_rx_valid = 1'b0;
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("idle_after_reset", {o_tx_valid, o_busy, o_req_ready}, 3'b001);

        // Register round trip using the bench register model as responder
        wr_txn(8'h03, 32'hCAFEF00D, 1'b0);
        g = '{1, 0, 2, 0};
        rd_txn(8'h03, reg_model[8'h03], 4, g, 1'b0, 32'hCAFEF00D);

        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("tx_queue_empty", exp_tx.size(), 0);
        chk("rsp_queue_empty", exp_rsp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
